// File: rtl/bus_pkg.sv
// Shared constants and state encoding for the serial system bus master transmitter.
package bus_pkg;

    localparam int ADDR_W         = 12;
    localparam int DATA_W         = 8;
    localparam int BURST_W        = 13;
    localparam int TIMEOUT_CYCLES = 255;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ADDR_TX,
        BEAT_WAIT,
        DATA_TX
    } master_tx_state_t;

endpackage

// File: rtl/master_out_port_piso_shift.sv
// Parallel-in / serial-out shifter, LSB first; zeros fill from the top so a drained register reads 0.
module piso_shift #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         serial_out
);

    logic [W-1:0] sh_q, sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load)
            sh_d = din;
        else if (shift)
            sh_d = {1'b0, sh_q[W-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sh_q <= '0;
        else
            sh_q <= sh_d;
    end

    assign serial_out = sh_q[0];

endmodule

// File: rtl/master_out_port.sv
// Bus-master request transmitter: serialises addr/data LSB-first behind an m_valid/s_ready handshake.
// Optional request timeout is compiled in with `define MASTER_OUT_TIMEOUT_EN.
module master_out_port #(
    parameter int ADDR_W  = bus_pkg::ADDR_W,
    parameter int DATA_W  = bus_pkg::DATA_W,
    parameter int BURST_W = bus_pkg::BURST_W
`ifdef MASTER_OUT_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = bus_pkg::TIMEOUT_CYCLES
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [DATA_W-1:0]  cmd_wdata,
    input  logic [BURST_W-1:0] cmd_burst,
    input  logic               wdata_valid,
    output logic               wdata_ready,
    input  logic [DATA_W-1:0]  wdata,
    input  logic               s_ready,
    output logic               m_valid,
    output logic               tx_address,
    output logic               tx_data,
    output logic               read_enable,
    output logic               write_enable,
    output logic [BURST_W-1:0] burst,
    output logic               tx_done,
    output logic               tx_error
);

    import bus_pkg::*;

    localparam int CNT_W = $clog2((ADDR_W > DATA_W) ? ADDR_W : DATA_W);
    localparam int BC_W  = BURST_W - 1;

    // Bit 0 of each phase goes out in the handshake cycle; the counters cover the remaining bits.
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 2);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 2);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [BC_W-1:0]  BEAT_ONE  = BC_W'(1);

    master_tx_state_t state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BC_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic               write_q, write_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               loaded_q, loaded_d;

    logic              addr_load, addr_shift, addr_ser;
    logic              data_load, data_shift, data_ser;
    logic [DATA_W-1:0] data_din;
    logic [BC_W-1:0]   n_beats;

    assign n_beats = burst_q[BURST_W-1:1];

`ifdef MASTER_OUT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tx_error_q, tx_error_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        beat_cnt_d  = beat_cnt_q;
        write_d     = write_q;
        burst_d     = burst_q;
        loaded_d    = loaded_q;
        addr_load   = 1'b0;
        addr_shift  = 1'b0;
        data_load   = 1'b0;
        data_shift  = 1'b0;
        data_din    = cmd_wdata;
        wdata_ready = 1'b0;
        m_valid     = 1'b0;
        tx_done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    write_d    = cmd_write;
                    burst_d    = cmd_burst;
                    addr_load  = 1'b1;
                    data_load  = 1'b1;
                    data_din   = cmd_write ? cmd_wdata : '0;
                    beat_cnt_d = '0;
                    loaded_d   = 1'b0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                m_valid = 1'b1;
                if (s_ready) begin
                    addr_shift = 1'b1;
                    data_shift = 1'b1;
                    cnt_d      = '0;
                    state_d    = ADDR_TX;
                end
            end
            ADDR_TX: begin
                // Data shifter runs in lockstep and drains to zero after the first data byte.
                addr_shift = 1'b1;
                data_shift = 1'b1;
                cnt_d      = cnt_q + CNT_ONE;
                if (cnt_q == ADDR_LAST) begin
                    cnt_d = '0;
                    if (write_q && burst_q[0] && (n_beats != '0)) begin
                        beat_cnt_d = BEAT_ONE;
                        state_d    = BEAT_WAIT;
                    end else begin
                        tx_done = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            BEAT_WAIT: begin
                if (!loaded_q) begin
                    wdata_ready = wdata_valid;
                    if (wdata_valid) begin
                        data_load = 1'b1;
                        data_din  = wdata;
                        loaded_d  = 1'b1;
                    end
                end else begin
                    m_valid = 1'b1;
                    if (s_ready) begin
                        data_shift = 1'b1;
                        loaded_d   = 1'b0;
                        cnt_d      = '0;
                        state_d    = DATA_TX;
                    end
                end
            end
            DATA_TX: begin
                data_shift = 1'b1;
                cnt_d      = cnt_q + CNT_ONE;
                if (cnt_q == DATA_LAST) begin
                    cnt_d = '0;
                    if (beat_cnt_q == n_beats) begin
                        tx_done = 1'b1;
                        state_d = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_ONE;
                        state_d    = BEAT_WAIT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef MASTER_OUT_TIMEOUT_EN
        tmo_cnt_d  = '0;
        tx_error_d = 1'b0;
        if (m_valid && !s_ready) begin
            if (tmo_cnt_q == TMO_LAST) begin
                state_d    = IDLE;
                loaded_d   = 1'b0;
                tx_error_d = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_ONE;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            beat_cnt_q <= '0;
            write_q    <= 1'b0;
            burst_q    <= '0;
            loaded_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            beat_cnt_q <= beat_cnt_d;
            write_q    <= write_d;
            burst_q    <= burst_d;
            loaded_q   <= loaded_d;
        end
    end

`ifdef MASTER_OUT_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q  <= '0;
            tx_error_q <= 1'b0;
        end else begin
            tmo_cnt_q  <= tmo_cnt_d;
            tx_error_q <= tx_error_d;
        end
    end

    assign tx_error = tx_error_q;
`else
    assign tx_error = 1'b0;
`endif

    piso_shift #(.W(ADDR_W)) u_addr_sh (
        .clk        (clk),
        .reset      (reset),
        .load       (addr_load),
        .shift      (addr_shift),
        .din        (cmd_addr),
        .serial_out (addr_ser)
    );

    piso_shift #(.W(DATA_W)) u_data_sh (
        .clk        (clk),
        .reset      (reset),
        .load       (data_load),
        .shift      (data_shift),
        .din        (data_din),
        .serial_out (data_ser)
    );

    assign cmd_ready    = (state_q == IDLE);
    assign tx_address   = ((state_q == REQ) || (state_q == ADDR_TX)) ? addr_ser : 1'b0;
    assign tx_data      = ((state_q == REQ) || (state_q == ADDR_TX) || (state_q == DATA_TX) ||
                           ((state_q == BEAT_WAIT) && loaded_q)) ? data_ser : 1'b0;
    assign read_enable  = (state_q != IDLE) && !write_q;
    assign write_enable = (state_q != IDLE) && write_q;
    assign burst        = (state_q != IDLE) ? burst_q : '0;

endmodule

// File: tb/tb_master_out_port.sv
// Directed bench for master_out_port: single write/read, write burst, stall, N=0 burst and mid-transfer reset.
module tb_master_out_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [11:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic [12:0] cmd_burst;
    logic        wdata_valid, wdata_ready;
    logic [7:0]  wdata;
    logic        s_ready, m_valid, tx_address, tx_data;
    logic        read_enable, write_enable;
    logic [12:0] burst;
    logic        tx_done, tx_error;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    master_out_port dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_burst    (cmd_burst),
        .wdata_valid  (wdata_valid),
        .wdata_ready  (wdata_ready),
        .wdata        (wdata),
        .s_ready      (s_ready),
        .m_valid      (m_valid),
        .tx_address   (tx_address),
        .tx_data      (tx_data),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .burst        (burst),
        .tx_done      (tx_done),
        .tx_error     (tx_error)
    );

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic cyc;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
        cmd_burst = '0; wdata_valid = 0; wdata = '0; s_ready = 0;
        cyc; cyc; #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        n_cmp++;
        if ({m_valid, tx_address, tx_data, read_enable, write_enable, wdata_ready, tx_done, tx_error} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 00000000",
                     {m_valid, tx_address, tx_data, read_enable, write_enable, wdata_ready, tx_done, tx_error});
        end
        n_cmp++;
        if (burst !== 13'h0) begin n_bad++; $display("FAIL reset_burst: got %h want 0000", burst); end
        cyc; reset = 1'b0; #1;
    endtask

    task automatic test_write_single;
        logic [11:0] a; logic [7:0] d; int dn, done_at, mv, bad;
        a = '0; d = '0; dn = 0; done_at = 0; mv = 0; bad = 0;
        cyc; cmd_valid = 1; cmd_write = 1; cmd_addr = 12'h5A3; cmd_wdata = 8'hC6; cmd_burst = '0; s_ready = 1; #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL single_cmd_ready: got %b want 1", cmd_ready); end
        for (int k = 1; k <= 12; k++) begin
            cyc; cmd_valid = 0; #1;
            a[k-1] = tx_address;
            if (k <= 8) d[k-1] = tx_data; else if (tx_data !== 1'b0) bad++;
            if (tx_done === 1'b1) begin dn++; done_at = k; end
            if (m_valid === 1'b1) mv++;
            if (write_enable !== 1'b1 || read_enable !== 1'b0 || cmd_ready !== 1'b0) bad++;
        end
        n_cmp++;
        if (a !== 12'h5A3) begin n_bad++; $display("FAIL single_addr_serial: got %h want 5a3", a); end
        n_cmp++;
        if (d !== 8'hC6) begin n_bad++; $display("FAIL single_data_serial: got %h want c6", d); end
        n_cmp++;
        if (dn != 1 || done_at != 12) begin n_bad++; $display("FAIL single_tx_done: got %0d pulses at %0d want 1 at 12", dn, done_at); end
        n_cmp++;
        if (mv != 1) begin n_bad++; $display("FAIL single_m_valid_cycles: got %0d want 1", mv); end
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL single_enables: got %0d bad cycles want 0", bad); end
        cyc; #1;
        n_cmp++;
        if (cmd_ready !== 1'b1 || write_enable !== 1'b0 || tx_done !== 1'b0) begin
            n_bad++; $display("FAIL single_idle_after: got rdy=%b we=%b done=%b want 1 0 0", cmd_ready, write_enable, tx_done);
        end
    endtask

    task automatic test_read_burst;
        logic [11:0] a; int dn, done_at, hs, bad;
        a = '0; dn = 0; done_at = 0; hs = 0; bad = 0;
        cyc; cmd_valid = 1; cmd_write = 0; cmd_addr = 12'h0F0; cmd_wdata = 8'hFF; cmd_burst = 13'h009; s_ready = 1; #1;
        for (int k = 1; k <= 16; k++) begin
            cyc; cmd_valid = 0; #1;
            if (k <= 12) begin
                a[k-1] = tx_address;
                if (burst !== 13'h009 || read_enable !== 1'b1 || write_enable !== 1'b0) bad++;
            end
            if (tx_data !== 1'b0) bad++;
            if (m_valid === 1'b1 && s_ready === 1'b1) hs++;
            if (tx_done === 1'b1) begin dn++; done_at = k; end
        end
        n_cmp++;
        if (a !== 12'h0F0) begin n_bad++; $display("FAIL read_addr_serial: got %h want 0f0", a); end
        n_cmp++;
        if (hs != 1) begin n_bad++; $display("FAIL read_handshakes: got %0d want 1", hs); end
        n_cmp++;
        if (dn != 1 || done_at != 12) begin n_bad++; $display("FAIL read_tx_done: got %0d pulses at %0d want 1 at 12", dn, done_at); end
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL read_held_outputs: got %0d bad cycles want 0", bad); end
        n_cmp++;
        if (cmd_ready !== 1'b1 || burst !== 13'h0) begin
            n_bad++; $display("FAIL read_idle_after: got rdy=%b burst=%h want 1 0000", cmd_ready, burst);
        end
    endtask

    task automatic test_write_burst;
        logic [11:0] a; logic [7:0] beats [3]; logic [7:0] wq [3];
        int dn, done_at, hs, wr, pos, bad;
        wq[0] = 8'h11; wq[1] = 8'h22; wq[2] = 8'h00;
        beats[0] = '0; beats[1] = '0; beats[2] = '0;
        a = '0; dn = 0; done_at = 0; hs = 0; wr = 0; pos = -1; bad = 0;
        cyc; cmd_valid = 1; cmd_write = 1; cmd_addr = 12'h3C5; cmd_wdata = 8'hC6; cmd_burst = 13'h005;
        s_ready = 1; wdata_valid = 1; wdata = wq[0]; #1;
        for (int k = 1; k <= 60 && dn == 0; k++) begin
            cyc; cmd_valid = 0; wdata = wq[(wr > 2) ? 2 : wr]; #1;
            if (m_valid === 1'b1 && s_ready === 1'b1) begin hs++; pos = 0; end
            if (pos >= 0 && pos < 8 && hs >= 1 && hs <= 3) begin beats[hs-1][pos] = tx_data; pos++; end
            if (k <= 12) a[k-1] = tx_address; else if (tx_address !== 1'b0) bad++;
            if (wdata_ready === 1'b1) wr++;
            if (tx_done === 1'b1) begin dn++; done_at = k; end
        end
        wdata_valid = 0;
        n_cmp++;
        if (hs != 3) begin n_bad++; $display("FAIL burst_handshakes: got %0d want 3", hs); end
        n_cmp++;
        if (beats[0] !== 8'hC6) begin n_bad++; $display("FAIL burst_beat0: got %h want c6", beats[0]); end
        n_cmp++;
        if (beats[1] !== 8'h11) begin n_bad++; $display("FAIL burst_beat1: got %h want 11", beats[1]); end
        n_cmp++;
        if (beats[2] !== 8'h22) begin n_bad++; $display("FAIL burst_beat2: got %h want 22", beats[2]); end
        n_cmp++;
        if (wr != 2) begin n_bad++; $display("FAIL burst_wdata_ready: got %0d pulses want 2", wr); end
        n_cmp++;
        if (dn != 1 || done_at != 30) begin n_bad++; $display("FAIL burst_tx_done: got %0d pulses at %0d want 1 at 30", dn, done_at); end
        n_cmp++;
        if (a !== 12'h3C5) begin n_bad++; $display("FAIL burst_addr_serial: got %h want 3c5", a); end
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL burst_addr_idle_zero: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_sready_stall;
        logic [11:0] a; int dn, done_at, hs, bad;
        a = '0; dn = 0; done_at = 0; hs = 0; bad = 0;
        cyc; cmd_valid = 1; cmd_write = 1; cmd_addr = 12'h2B7; cmd_wdata = 8'h5D; cmd_burst = '0; s_ready = 0; #1;
        for (int k = 1; k <= 34; k++) begin
            // A different command stays on the inputs; it must be ignored while busy.
            cyc; cmd_valid = (k <= 25); cmd_addr = 12'hFFE; cmd_wdata = 8'h00; s_ready = (k >= 21); #1;
            if (k <= 20 && (m_valid !== 1'b1 || tx_address !== 1'b1)) bad++;
            if (k >= 21 && k <= 32) a[k-21] = tx_address;
            if (m_valid === 1'b1 && s_ready === 1'b1) hs++;
            if (tx_done === 1'b1) begin dn++; done_at = k; end
        end
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
        n_cmp++;
        if (a !== 12'h2B7) begin n_bad++; $display("FAIL stall_addr_serial: got %h want 2b7", a); end
        n_cmp++;
        if (hs != 1) begin n_bad++; $display("FAIL stall_handshakes: got %0d want 1", hs); end
        n_cmp++;
        if (dn != 1 || done_at != 32) begin n_bad++; $display("FAIL stall_tx_done: got %0d pulses at %0d want 1 at 32", dn, done_at); end
    endtask

    task automatic test_burst_n0;
        int dn, done_at, wr;
        dn = 0; done_at = 0; wr = 0;
        cyc; cmd_valid = 1; cmd_write = 1; cmd_addr = 12'h001; cmd_wdata = 8'h80; cmd_burst = 13'h001;
        s_ready = 1; wdata_valid = 1; wdata = 8'h55; #1;
        for (int k = 1; k <= 16; k++) begin
            cyc; cmd_valid = 0; #1;
            if (wdata_ready === 1'b1) wr++;
            if (tx_done === 1'b1) begin dn++; done_at = k; end
        end
        wdata_valid = 0;
        n_cmp++;
        if (dn != 1 || done_at != 12) begin n_bad++; $display("FAIL n0_tx_done: got %0d pulses at %0d want 1 at 12", dn, done_at); end
        n_cmp++;
        if (wr != 0) begin n_bad++; $display("FAIL n0_wdata_ready: got %0d pulses want 0", wr); end
    endtask

    task automatic test_reset_mid;
        int dn, mv;
        dn = 0; mv = 0;
        cyc; cmd_valid = 1; cmd_write = 1; cmd_addr = 12'h5A3; cmd_wdata = 8'hC6; cmd_burst = 13'h009; s_ready = 1; #1;
        for (int k = 1; k <= 6; k++) begin
            cyc; cmd_valid = 0; #1;
        end
        cyc; #1; reset = 1'b1; #1;
        n_cmp++;
        if ({m_valid, tx_address, tx_data, read_enable, write_enable, wdata_ready, tx_done, tx_error} !== 8'h00 || burst !== 13'h0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got %b burst=%h want 00000000 burst=0000",
                     {m_valid, tx_address, tx_data, read_enable, write_enable, wdata_ready, tx_done, tx_error}, burst);
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_cmd_ready: got %b want 1", cmd_ready); end
        cyc; reset = 1'b0; #1;
        for (int k = 1; k <= 15; k++) begin
            cyc; #1;
            if (tx_done === 1'b1) dn++;
            if (m_valid === 1'b1) mv++;
        end
        n_cmp++;
        if (dn != 0 || mv != 0) begin n_bad++; $display("FAIL midreset_no_done: got done=%0d m_valid=%0d want 0 0", dn, mv); end
    endtask

    initial begin
        test_reset;
        test_write_single;
        test_read_burst;
        test_write_burst;
        test_sready_stall;
        test_burst_n0;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
